audio_adc_scheduler: RTL and testbench

AUDIO_ADC_SCHEDULER -- requirements
Module: audio_adc_scheduler

---
 rtl/audio_adc_scheduler.sv | 145 ++++++++++++++
 tb/tb_audio_adc_scheduler.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_adc_scheduler.sv
// Paces SPI ADC frame requests round-robin over the enabled channels and
// buffers channel-tagged conversion results in a small FIFO for the consumer.
module audio_adc_scheduler #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk_40MHz,
    input  logic        nReset,
    input  logic [7:0]  chan_enable,
    input  logic [15:0] pace_div,
    input  logic        clear_flags,
    output logic        frame_start,
    output logic [2:0]  frame_channel,
    input  logic        frame_busy,
    input  logic        frame_done,
    input  logic [11:0] frame_data,
    output logic        sample_valid,
    input  logic        sample_ready,
    output logic [2:0]  sample_channel,
    output logic [11:0] sample_data,
    output logic        overflow,
    output logic        pace_overrun
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, BUSY} state_t;

    state_t      state, state_nxt;
    logic [15:0] pace_cnt;
    logic        pace_tick;
    logic        load_frame;
    logic [2:0]  last_req;
    logic [2:0]  prev_channel;
    logic [2:0]  next_chan;

    logic [14:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic [14:0] head;
    logic        push_req, push, pop, full;

    // Lowest enabled channel above the last request, else wrap to lowest enabled.
    function automatic logic [2:0] pick_channel(input logic [2:0] last, input logic [7:0] en);
        logic [2:0] pick;
        pick = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (en[i]) pick = 3'(i);
        end
        for (int i = 7; i >= 0; i--) begin
            if (en[i] && (3'(i) > last)) pick = 3'(i);
        end
        return pick;
    endfunction

    assign next_chan = pick_channel(last_req, chan_enable);
    assign pace_tick = (pace_cnt == 16'd0);

    always_ff @(posedge clk_40MHz or negedge nReset) begin
        if (!nReset) begin
            pace_cnt <= '0;
        end else if (pace_tick) begin
            pace_cnt <= pace_div;
        end else begin
            pace_cnt <= pace_cnt - 16'd1;
        end
    end

    always_comb begin
        state_nxt  = state;
        load_frame = 1'b0;
        unique case (state)
            IDLE: begin
                if (pace_tick && (|chan_enable) && !frame_busy) begin
                    state_nxt  = START;
                    load_frame = 1'b1;
                end
            end
            START:   state_nxt = BUSY;
            BUSY:    if (frame_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign frame_start = (state == START);

    always_ff @(posedge clk_40MHz or negedge nReset) begin
        if (!nReset) begin
            state         <= IDLE;
            frame_channel <= 3'd0;
            last_req      <= 3'd7;
            prev_channel  <= 3'd0;
        end else begin
            state <= state_nxt;
            if (load_frame) begin
                frame_channel <= next_chan;
                last_req      <= next_chan;
            end
            // The ADC returns the conversion addressed by the previous frame.
            if (frame_done) prev_channel <= frame_channel;
        end
    end

    assign push_req = frame_done && chan_enable[prev_channel];
    assign pop      = sample_valid && sample_ready;
    assign full     = (count == FULL_CNT);
    assign push     = push_req && (!full || pop);

    always_ff @(posedge clk_40MHz) begin
        if (push) mem[wr_ptr] <= {prev_channel, frame_data};
    end

    always_ff @(posedge clk_40MHz or negedge nReset) begin
        if (!nReset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign sample_valid   = (count != '0);
    assign head           = mem[rd_ptr];
    assign sample_channel = sample_valid ? head[14:12] : 3'd0;
    assign sample_data    = sample_valid ? head[11:0]  : 12'd0;

    // Sticky flags: a set event in the same cycle wins over clear_flags.
    always_ff @(posedge clk_40MHz or negedge nReset) begin
        if (!nReset) begin
            overflow     <= 1'b0;
            pace_overrun <= 1'b0;
        end else begin
            if (push_req && full && !pop) overflow <= 1'b1;
            else if (clear_flags)         overflow <= 1'b0;
            if (pace_tick && (state != IDLE)) pace_overrun <= 1'b1;
            else if (clear_flags)              pace_overrun <= 1'b0;
        end
    end
endmodule

// File: tb/tb_audio_adc_scheduler.sv
// Directed bench for audio_adc_scheduler: behavioural SPI frame engine/ADC,
// scoreboard queue of expected FIFO entries, immediate-assertion checks.
`timescale 1ns/1ps
module tb_audio_adc_scheduler;
    localparam int DEPTH = 4;

    logic        clk_40MHz;
    logic        nReset;
    logic [7:0]  chan_enable;
    logic [15:0] pace_div;
    logic        clear_flags;
    logic        frame_start;
    logic [2:0]  frame_channel;
    logic        frame_busy;
    logic        frame_done;
    logic [11:0] frame_data;
    logic        sample_valid;
    logic        sample_ready;
    logic [2:0]  sample_channel;
    logic [11:0] sample_data;
    logic        overflow;
    logic        pace_overrun;

    audio_adc_scheduler #(.FIFO_DEPTH(DEPTH)) dut (
        .clk_40MHz      (clk_40MHz),
        .nReset         (nReset),
        .chan_enable    (chan_enable),
        .pace_div       (pace_div),
        .clear_flags    (clear_flags),
        .frame_start    (frame_start),
        .frame_channel  (frame_channel),
        .frame_busy     (frame_busy),
        .frame_done     (frame_done),
        .frame_data     (frame_data),
        .sample_valid   (sample_valid),
        .sample_ready   (sample_ready),
        .sample_channel (sample_channel),
        .sample_data    (sample_data),
        .overflow       (overflow),
        .pace_overrun   (pace_overrun)
    );

    initial begin
        clk_40MHz = 1'b0;
        forever #5 clk_40MHz = ~clk_40MHz;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame engine / ADC model: data carries the channel the ADC actually converted.
    int         eng_cnt = 0;
    int         eng_len = 20;
    int         overlap = 0;
    logic [2:0] eng_ch = 3'd0;
    logic [2:0] adc_prev = 3'd0;
    logic [7:0] seq = 8'd0;

    initial begin : engine
        frame_busy = 1'b0;
        frame_done = 1'b0;
        frame_data = 12'd0;
        forever begin
            @(negedge clk_40MHz);
            frame_done = 1'b0;
            if (eng_cnt > 0) begin
                if (frame_start) overlap++;
                eng_cnt--;
                if (eng_cnt == 0) begin
                    frame_busy = 1'b0;
                    frame_done = 1'b1;
                    seq++;
                    frame_data = {adc_prev, 1'b0, seq};
                    adc_prev   = eng_ch;
                end
            end else if (frame_start) begin
                frame_busy = 1'b1;
                eng_ch     = frame_channel;
                eng_cnt    = eng_len;
            end
        end
    end

    // Scoreboard and logs
    logic [14:0] exp_q[$];
    logic [2:0]  pop_log[$];
    logic [2:0]  fs_log[$];
    int          fs_cyc[$];
    int          cyc = 0;
    int          rel_cyc = 0;
    int          dn_cnt = 0;
    logic [2:0]  mdl_prev, mdl_fc, mdl_last;
    logic        exp_ovf;
    logic        was_rst;
    logic [7:0]  en_prev;
    bit          tag_chk = 1'b0;

    function automatic logic [2:0] exp_sel(input logic [2:0] last, input logic [7:0] en);
        logic [2:0] c;
        for (int k = 1; k <= 8; k++) begin
            c = last + 3'(k);
            if (en[c]) return c;
        end
        return 3'd0;
    endfunction

    initial begin : monitor
        logic [14:0] x;
        logic [2:0]  e;
        logic        pop, set_ovf;
        mdl_prev = 3'd0; mdl_fc = 3'd0; mdl_last = 3'd7;
        exp_ovf = 1'b0; was_rst = 1'b1; en_prev = 8'd0;
        forever begin
            @(negedge clk_40MHz);
            #4;
            cyc++;
            if (!nReset) begin
                exp_q.delete();
                mdl_prev = 3'd0; mdl_fc = 3'd0; mdl_last = 3'd7;
                exp_ovf = 1'b0; was_rst = 1'b1; en_prev = chan_enable;
                continue;
            end
            if (was_rst) begin
                rel_cyc = cyc;
                was_rst = 1'b0;
            end
            chk("valid", sample_valid, exp_q.size() != 0);
            chk("overflow", overflow, exp_ovf);
            if (frame_start) begin
                e = exp_sel(mdl_last, en_prev);
                chk("frame_channel", frame_channel, e);
                mdl_fc = e; mdl_last = e;
                fs_log.push_back(e);
                fs_cyc.push_back(cyc);
            end
            pop = sample_valid && sample_ready;
            if (pop && exp_q.size() > 0) begin
                x = exp_q.pop_front();
                chk("sample_channel", sample_channel, x[14:12]);
                chk("sample_data", sample_data, x[11:0]);
                if (tag_chk) chk("adc_tag", sample_data[11:9], x[14:12]);
                pop_log.push_back(x[14:12]);
            end
            set_ovf = 1'b0;
            if (frame_done) begin
                dn_cnt++;
                if (chan_enable[mdl_prev]) begin
                    if (exp_q.size() < DEPTH) exp_q.push_back({mdl_prev, frame_data});
                    else set_ovf = 1'b1;
                end
                mdl_prev = mdl_fc;
            end
            if (set_ovf) exp_ovf = 1'b1;
            else if (clear_flags) exp_ovf = 1'b0;
            en_prev = chan_enable;
        end
    end

    task automatic step();
        @(negedge clk_40MHz);
        #1;
    endtask

    task automatic start_test();
        step();
        nReset = 1'b0;
        adc_prev = 3'd0;
        fs_log.delete(); fs_cyc.delete(); pop_log.delete();
        dn_cnt = 0;
        step();
        nReset = 1'b1;
    endtask

    task automatic wait_fs(input int n, input int budget);
        int k;
        k = 0;
        while (fs_log.size() < n && k < budget) begin step(); k++; end
        if (fs_log.size() < n) chk("frame_start_timeout", fs_log.size(), n);
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (!frame_done && k < budget) begin step(); k++; end
        if (!frame_done) chk("frame_done_timeout", frame_done, 1);
    endtask

    task automatic pulse_clear();
        step(); clear_flags = 1'b1;
        step(); clear_flags = 1'b0;
    endtask

    initial begin : stimulus
        logic [2:0] fs_a[4];
        logic [2:0] pop_a[4];
        int k, base_fs, base_pop;
        nReset = 1'b1; chan_enable = 8'd0; pace_div = 16'd0;
        clear_flags = 1'b0; sample_ready = 1'b0;
        #1 nReset = 1'b0;
        repeat (3) step();
        chk("rst_frame_start", frame_start, 0);
        chk("rst_frame_channel", frame_channel, 0);
        chk("rst_sample_valid", sample_valid, 0);
        chk("rst_sample_channel", sample_channel, 0);
        chk("rst_sample_data", sample_data, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_pace_overrun", pace_overrun, 0);

        // Two channels, 1000-clock pacing
        chan_enable = 8'h03; pace_div = 16'd999; sample_ready = 1'b1;
        eng_len = 20; tag_chk = 1'b1;
        start_test();
        wait_fs(4, 5000);
        repeat (40) step();
        fs_a = '{3'd0, 3'd1, 3'd0, 3'd1};
        pop_a = '{3'd0, 3'd0, 3'd1, 3'd0};
        chk("first_tick", fs_cyc[0] - rel_cyc, 1);
        for (int i = 0; i < 4; i++) chk("seq03_frame", fs_log[i], fs_a[i]);
        for (int i = 0; i < 3; i++) chk("start_spacing", fs_cyc[i+1] - fs_cyc[i], 1000);
        chk("seq03_pops", pop_log.size(), 4);
        for (int i = 0; i < 4; i++) chk("seq03_tag", pop_log[i], pop_a[i]);

        // Channels 2 and 7; reset-default ch0 result is discarded
        chan_enable = 8'h84;
        start_test();
        wait_fs(4, 5000);
        repeat (40) step();
        fs_a = '{3'd2, 3'd7, 3'd2, 3'd7};
        pop_a = '{3'd2, 3'd7, 3'd2, 3'd0};
        for (int i = 0; i < 4; i++) chk("seq84_frame", fs_log[i], fs_a[i]);
        chk("seq84_pops", pop_log.size(), 3);
        for (int i = 0; i < 3; i++) chk("seq84_tag", pop_log[i], pop_a[i]);

        // FIFO overflow, clear priority, push+pop when full
        chan_enable = 8'h01; pace_div = 16'd99; eng_len = 10; sample_ready = 1'b0;
        start_test();
        k = 0;
        while (dn_cnt < 5 && k < 1000) begin step(); k++; end
        chk("five_results", dn_cnt >= 5, 1);
        chk("ovf_set", overflow, 1);
        chk("full_valid", sample_valid, 1);
        wait_done(200);
        pulse_clear();
        chk("ovf_clear", overflow, 0);
        wait_done(200);
        clear_flags = 1'b1;
        step(); clear_flags = 1'b0;
        chk("ovf_set_beats_clear", overflow, 1);
        pulse_clear();
        chk("ovf_clear2", overflow, 0);
        wait_done(200);
        sample_ready = 1'b1;
        step(); sample_ready = 1'b0; chan_enable = 8'h00;
        chk("full_pushpop_no_ovf", overflow, 0);
        chk("full_pushpop_pops", pop_log.size(), 1);
        chk("full_pushpop_valid", sample_valid, 1);
        sample_ready = 1'b1;
        repeat (10) step();
        chk("drain_count", pop_log.size(), 5);
        chk("drain_empty", sample_valid, 0);

        // Pacing faster than the frame engine
        chan_enable = 8'h01; pace_div = 16'd0; eng_len = 400;
        start_test();
        repeat (1300) step();
        chk("overrun_set", pace_overrun, 1);
        chk("no_overlap", overlap, 0);
        chk("frames_ran", dn_cnt >= 2, 1);
        chk("one_start_per_done", (fs_log.size() == dn_cnt) || (fs_log.size() == dn_cnt + 1), 1);
        pulse_clear();
        chk("overrun_set_beats_clear", pace_overrun, 1);
        chan_enable = 8'h00;
        repeat (450) step();
        pulse_clear();
        chk("overrun_clear", pace_overrun, 0);
        base_fs = fs_log.size();
        repeat (50) step();
        chk("no_frame_when_disabled", fs_log.size(), base_fs);
        chk("disabled_no_overrun", pace_overrun, 0);

        // Reset pulsed mid-frame
        chan_enable = 8'h07; pace_div = 16'd199; eng_len = 50; tag_chk = 1'b0;
        start_test();
        wait_fs(2, 600);
        chk("pre_rst_channel", frame_channel, 1);
        repeat (10) step();
        nReset = 1'b0;
        #1;
        chk("mid_rst_frame_start", frame_start, 0);
        chk("mid_rst_frame_channel", frame_channel, 0);
        chk("mid_rst_sample_valid", sample_valid, 0);
        chk("mid_rst_sample_channel", sample_channel, 0);
        chk("mid_rst_sample_data", sample_data, 0);
        chk("mid_rst_overflow", overflow, 0);
        chk("mid_rst_pace_overrun", pace_overrun, 0);
        base_fs = fs_log.size();
        base_pop = pop_log.size();
        step(); nReset = 1'b1;
        wait_fs(base_fs + 1, 600);
        chk("resume_started", fs_log.size() > base_fs, 1);
        if (fs_log.size() > base_fs) chk("resume_channel", fs_log[base_fs], 0);
        chk("post_rst_push", pop_log.size() > base_pop, 1);
        if (pop_log.size() > base_pop) chk("post_rst_tag", pop_log[base_pop], 0);
        repeat (5) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
